lsu_data_memory: RTL and testbench

//  Parametrised word-organised data RAM behind the load/store stage of the RV32I core.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_load_ext.sv | 36 +++
 rtl/lsu_data_memory.sv | 112 +++++++++++
 tb/tb_lsu_data_memory.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and decode helpers for the load/store data memory.
package dmem_pkg;

   typedef enum logic [2:0] {
      MF_B  = 3'b000,
      MF_H  = 3'b001,
      MF_W  = 3'b010,
      MF_BU = 3'b100,
      MF_HU = 3'b101
   } mem_funct_e;

   typedef enum logic {
      S_CLEAR,
      S_IDLE
   } dmem_state_e;

   // Undefined width encodings are reported as misaligned so they never touch memory.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] bo);
      case (funct3)
         MF_B, MF_BU: is_misaligned = 1'b0;
         MF_H, MF_HU: is_misaligned = bo[0];
         MF_W:        is_misaligned = (bo != 2'b00);
         default:     is_misaligned = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Selects the addressed byte/half lane of a memory word and sign/zero-extends it.
module dmem_load_ext
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  bo,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = word[7:0];
      case (bo)
         2'd0: lane_b = word[7:0];
         2'd1: lane_b = word[15:8];
         2'd2: lane_b = word[23:16];
         2'd3: lane_b = word[31:24];
         default: lane_b = word[7:0];
      endcase
      lane_h = bo[1] ? word[31:16] : word[15:0];

      data = '0;
      case (funct3)
         MF_B:  data = {{24{lane_b[7]}}, lane_b};
         MF_BU: data = {24'd0, lane_b};
         MF_H:  data = {{16{lane_h[15]}}, lane_h};
         MF_HU: data = {16'd0, lane_h};
         MF_W:  data = word;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/lsu_data_memory.sv
// Word-organised byte-enable data RAM with registered loads, error flags and a post-reset clear sweep.
//   state   | meaning
//   S_CLEAR | zeroing mem[ptr] one word per cycle, port busy
//   S_IDLE  | port ready, one load or store accepted per cycle
module lsu_data_memory
   import dmem_pkg::*;
#(
   parameter int DEPTH    = 2048,
   parameter int AW       = 32,
   parameter int CLEAR_EN = 1
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_req,
   input  logic          i_wren,
   input  logic [2:0]    i_funct3,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic          o_ready,
   output logic          o_rvalid,
   output logic [31:0]   o_rdata,
   output logic          o_misaligned,
   output logic          o_addr_err
);

   localparam int IW = $clog2(DEPTH);

   dmem_state_e   state_q, state_d;
   logic [IW-1:0] ptr_q;
   logic [3:0][7:0] mem [DEPTH];

   logic [IW-1:0] widx;
   logic [1:0]    bo;
   logic          mis_c, range_err, accept, do_write;
   logic [3:0]    be;
   logic [31:0]   wdata_rep, ext_data;

   assign widx      = i_addr[IW+1:2];
   assign bo        = i_addr[1:0];
   assign range_err = |i_addr[AW-1:IW+2];
   assign mis_c     = is_misaligned(i_funct3, bo);
   assign accept    = i_req & o_ready;
   assign do_write  = accept & i_wren & ~mis_c & ~range_err;

   always_comb begin
      state_d = state_q;
      o_ready = 1'b0;
      case (state_q)
         S_CLEAR: if (ptr_q == IW'(DEPTH - 1)) state_d = S_IDLE;
         S_IDLE:  o_ready = 1'b1;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      be        = 4'hF;
      wdata_rep = i_wdata;
      case (i_funct3)
         MF_B, MF_BU: begin
            be        = 4'b0001 << bo;
            wdata_rep = {4{i_wdata[7:0]}};
         end
         MF_H, MF_HU: begin
            be        = 4'b0011 << bo;
            wdata_rep = {2{i_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= (CLEAR_EN != 0) ? S_CLEAR : S_IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_CLEAR) ptr_q <= ptr_q + 1'b1;
      end
   end

   // Storage is not reset; the clear sweep is what gives it defined contents.
   always_ff @(posedge i_clk) begin
      if (state_q == S_CLEAR) begin
         mem[ptr_q] <= '0;
      end else if (do_write) begin
         for (int l = 0; l < 4; l++)
            if (be[l]) mem[widx][l] <= wdata_rep[8*l +: 8];
      end
   end

   dmem_load_ext u_load_ext (
      .word   (mem[widx]),
      .bo     (bo),
      .funct3 (i_funct3),
      .data   (ext_data)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_rvalid     <= 1'b0;
         o_rdata      <= '0;
         o_misaligned <= 1'b0;
         o_addr_err   <= 1'b0;
      end else begin
         o_rvalid     <= accept & ~i_wren;
         o_misaligned <= accept & mis_c;
         o_addr_err   <= accept & range_err;
         if (accept & ~i_wren) o_rdata <= (mis_c | range_err) ? 32'd0 : ext_data;
      end
   end

endmodule

// File: tb/tb_lsu_data_memory.sv
// Directed checks of lsu_data_memory (DEPTH=16): clear sweep, sub-word access, errors, reset restart.
module tb_lsu_data_memory;

   localparam int DEPTH = 16;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_req = 1'b0;
   logic        i_wren = 1'b0;
   logic [2:0]  i_funct3 = 3'b010;
   logic [31:0] i_addr = '0;
   logic [31:0] i_wdata = '0;
   logic        o_ready, o_rvalid, o_misaligned, o_addr_err;
   logic [31:0] o_rdata;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] last_rdata = '0;

   lsu_data_memory #(.DEPTH(DEPTH), .AW(32), .CLEAR_EN(1)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_req        (i_req),
      .i_wren       (i_wren),
      .i_funct3     (i_funct3),
      .i_addr       (i_addr),
      .i_wdata      (i_wdata),
      .o_ready      (o_ready),
      .o_rvalid     (o_rvalid),
      .o_rdata      (o_rdata),
      .o_misaligned (o_misaligned),
      .o_addr_err   (o_addr_err)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      string       name;
      logic        wren;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_rvalid;
      logic [31:0] exp_rdata;
      logic        exp_mis;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic access(input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
      @(negedge i_clk);
      i_req = 1'b1; i_wren = wren; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
      @(posedge i_clk);
      #1;
      i_req = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      access(v.wren, v.f3, v.addr, v.wdata);
      if (v.exp_rvalid) last_rdata = v.exp_rdata;
      check({v.name, ".rvalid"}, 32'(o_rvalid), 32'(v.exp_rvalid));
      check({v.name, ".rdata"}, o_rdata, last_rdata);
      check({v.name, ".mis"}, 32'(o_misaligned), 32'(v.exp_mis));
      check({v.name, ".err"}, 32'(o_addr_err), 32'(v.exp_err));
   endtask

   task automatic count_sweep(input string name, input bit req_busy);
      int cnt;
      cnt = 0;
      if (req_busy) begin
         i_req = 1'b1; i_wren = 1'b0; i_funct3 = 3'b010; i_addr = 32'h8;
      end
      while (cnt < 100) begin
         @(posedge i_clk);
         #1;
         cnt++;
         if (cnt == 8) i_req = 1'b0;
         if (req_busy) check({name, ".busy_rvalid"}, 32'(o_rvalid), 32'd0);
         if (o_ready) break;
      end
      i_req = 1'b0;
      check({name, ".sweep_cycles"}, 32'(cnt), 32'(DEPTH));
   endtask

   function automatic vec_t mk(input string name, input logic wren, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic rv, input logic [31:0] rd, input logic mis,
                               input logic err);
      vec_t v;
      v.name = name; v.wren = wren; v.f3 = f3; v.addr = addr; v.wdata = wdata;
      v.exp_rvalid = rv; v.exp_rdata = rd; v.exp_mis = mis; v.exp_err = err;
      return v;
   endfunction

   initial begin
      vecs.push_back(mk("sw_8",      1, 3'b010, 32'h8,  32'h11223344, 0, 32'h0, 0, 0));
      vecs.push_back(mk("lb_9",      0, 3'b000, 32'h9,  32'h0, 1, 32'h00000033, 0, 0));
      vecs.push_back(mk("lh_a",      0, 3'b001, 32'hA,  32'h0, 1, 32'h00001122, 0, 0));
      vecs.push_back(mk("lw_8",      0, 3'b010, 32'h8,  32'h0, 1, 32'h11223344, 0, 0));
      vecs.push_back(mk("sb_b",      1, 3'b000, 32'hB,  32'h000000F0, 0, 32'h0, 0, 0));
      vecs.push_back(mk("lb_b",      0, 3'b000, 32'hB,  32'h0, 1, 32'hFFFFFFF0, 0, 0));
      vecs.push_back(mk("lbu_b",     0, 3'b100, 32'hB,  32'h0, 1, 32'h000000F0, 0, 0));
      vecs.push_back(mk("lw_8b",     0, 3'b010, 32'h8,  32'h0, 1, 32'hF0223344, 0, 0));
      vecs.push_back(mk("lhu_a",     0, 3'b101, 32'hA,  32'h0, 1, 32'h0000F022, 0, 0));
      vecs.push_back(mk("lh_a_neg",  0, 3'b001, 32'hA,  32'h0, 1, 32'hFFFFF022, 0, 0));
      vecs.push_back(mk("lw_6_mis",  0, 3'b010, 32'h6,  32'h0, 1, 32'h0, 1, 0));
      vecs.push_back(mk("sh_3_mis",  1, 3'b001, 32'h3,  32'h0000BEEF, 0, 32'h0, 1, 0));
      vecs.push_back(mk("lw_0",      0, 3'b010, 32'h0,  32'h0, 1, 32'h0, 0, 0));
      vecs.push_back(mk("lw_oor",    0, 3'b010, 32'(DEPTH*4), 32'h0, 1, 32'h0, 0, 1));
      vecs.push_back(mk("sw_top",    1, 3'b010, 32'hFFFF_FFFC, 32'hDEADBEEF, 0, 32'h0, 0, 1));
      vecs.push_back(mk("lw_3c",     0, 3'b010, 32'h3C, 32'h0, 1, 32'h0, 0, 0));
      vecs.push_back(mk("lh_both",   0, 3'b001, 32'h41, 32'h0, 1, 32'h0, 1, 1));
      vecs.push_back(mk("lw_8c",     0, 3'b010, 32'h8,  32'h0, 1, 32'hF0223344, 0, 0));
      vecs.push_back(mk("l_f3_011",  0, 3'b011, 32'h8,  32'h0, 1, 32'h0, 1, 0));
      vecs.push_back(mk("sh_12",     1, 3'b001, 32'h12, 32'h1234ABCD, 0, 32'h0, 0, 0));
      vecs.push_back(mk("lw_10",     0, 3'b010, 32'h10, 32'h0, 1, 32'hABCD0000, 0, 0));
      vecs.push_back(mk("lb_13",     0, 3'b000, 32'h13, 32'h0, 1, 32'hFFFFFFAB, 0, 0));
      vecs.push_back(mk("lhu_12",    0, 3'b101, 32'h12, 32'h0, 1, 32'h0000ABCD, 0, 0));
      vecs.push_back(mk("sw_1c",     1, 3'b010, 32'h1C, 32'hCAFEF00D, 0, 32'h0, 0, 0));
      vecs.push_back(mk("lw_1c",     0, 3'b010, 32'h1C, 32'h0, 1, 32'hCAFEF00D, 0, 0));

      // Reset state
      repeat (3) @(negedge i_clk);
      check("rst.ready",  32'(o_ready), 32'd0);
      check("rst.rvalid", 32'(o_rvalid), 32'd0);
      check("rst.rdata",  o_rdata, 32'd0);
      check("rst.mis",    32'(o_misaligned), 32'd0);
      check("rst.err",    32'(o_addr_err), 32'd0);
      i_reset = 1'b0;
      count_sweep("sweep0", 1'b0);

      for (int a = 0; a <= 60; a += 4) begin
         access(1'b0, 3'b010, 32'(a), 32'h0);
         check($sformatf("clr_lw_%0d.rvalid", a), 32'(o_rvalid), 32'd1);
         check($sformatf("clr_lw_%0d.rdata", a), o_rdata, 32'd0);
      end

      foreach (vecs[i]) apply(vecs[i]);

      // Reset in the middle of the sweep restarts it from word 0
      @(negedge i_clk);
      i_reset = 1'b1;
      @(negedge i_clk);
      i_reset = 1'b0;
      last_rdata = '0;
      check("rst2.rdata", o_rdata, 32'd0);
      repeat (5) @(negedge i_clk);
      check("mid_sweep.ready", 32'(o_ready), 32'd0);
      i_reset = 1'b1;
      @(negedge i_clk);
      check("rst3.ready", 32'(o_ready), 32'd0);
      i_reset = 1'b0;
      count_sweep("sweep1", 1'b1);

      apply(mk("post_lw_8",  0, 3'b010, 32'h8,  32'h0, 1, 32'h0, 0, 0));
      apply(mk("post_lw_10", 0, 3'b010, 32'h10, 32'h0, 1, 32'h0, 0, 0));
      apply(mk("post_lw_1c", 0, 3'b010, 32'h1C, 32'h0, 1, 32'h0, 0, 0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
